// File: rtl/fib_writeback_checker_if.sv
// Regfile write-back bus as driven by the Fibonacci test FSM.
// The checker only ever listens on it, through the slave modport.
interface fib_writeback_checker_if #(
   parameter int unsigned DATA_W = 16
);
   logic              reg_reset;
   logic              wr_en;
   logic [3:0]        wr_sel;
   logic [DATA_W-1:0] wr_data;

   modport master (output reg_reset, wr_en, wr_sel, wr_data);
   modport slave  (input  reg_reset, wr_en, wr_sel, wr_data);
endinterface

// File: rtl/fib_writeback_checker.sv
// Passive checker for the Fibonacci regfile test.
// It snoops regfile writes and compares each one with a locally generated
// Fibonacci stream. It reports done/pass, an error count, the first failing
// register and a timeout flag. Every output is a register, so the result of
// a write shows up one cycle after the write is sampled.
module fib_writeback_checker #(
   parameter int unsigned             DATA_W  = 16,
   parameter logic [DATA_W-1:0]       SEED0   = DATA_W'(1),
   parameter logic [DATA_W-1:0]       SEED1   = DATA_W'(2),
   parameter int unsigned             NUM_WR  = 16,
   parameter int unsigned             TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   fib_writeback_checker_if.slave i_wb,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_pass,
   output logic                  o_timeout,
   output logic [4:0]            o_err_count,
   output logic [3:0]            o_first_err_reg,
   output logic [DATA_W-1:0]     o_expected
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CHECK, S_DONE} state_t;

   state_t            r_state;
   logic [4:0]        r_idx;
   logic [DATA_W-1:0] r_exp_b;
   logic [TW-1:0]     r_timer;

   logic              w_miss;
   logic [4:0]        w_err_inc;
   logic              w_last;
   logic              w_tmo_hit;

   // The head of the stream (o_expected) is the value checked against this write.
   assign w_miss    = (i_wb.wr_sel != r_idx[3:0]) || (i_wb.wr_data != o_expected);
   assign w_err_inc = (o_err_count == 5'd31) ? o_err_count : o_err_count + 5'd1;
   assign w_last    = (r_idx == 5'(NUM_WR - 1));
   assign w_tmo_hit = (r_timer == TW'(TIMEOUT - 1));

   // Run control FSM.
   // It holds the stream state, the idle timer and all of the registered result outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= S_IDLE;
         r_idx           <= '0;
         r_exp_b         <= SEED1;
         r_timer         <= '0;
         o_busy          <= 1'b0;
         o_done          <= 1'b0;
         o_pass          <= 1'b0;
         o_timeout       <= 1'b0;
         o_err_count     <= '0;
         o_first_err_reg <= '0;
         o_expected      <= SEED0;
      end else if (i_wb.reg_reset) begin
         // Arming a new run always wins, including over a write in the same cycle.
         r_state         <= S_ARMED;
         r_idx           <= '0;
         r_exp_b         <= SEED1;
         r_timer         <= '0;
         o_busy          <= 1'b1;
         o_done          <= 1'b0;
         o_pass          <= 1'b0;
         o_timeout       <= 1'b0;
         o_err_count     <= '0;
         o_first_err_reg <= '0;
         o_expected      <= SEED0;
      end else begin
         case (r_state)
            S_ARMED, S_CHECK: begin
               if (i_wb.wr_en) begin
                  // A write always advances the stream by one, even when it is
                  // a duplicate or a skip. There is no attempt to resync.
                  r_timer    <= '0;
                  r_idx      <= r_idx + 5'd1;
                  o_expected <= r_exp_b;
                  r_exp_b    <= o_expected + r_exp_b;
                  if (w_miss) begin
                     o_err_count <= w_err_inc;
                     if (o_err_count == 5'd0)
                        o_first_err_reg <= i_wb.wr_sel;
                  end
                  if (w_last) begin
                     r_state <= S_DONE;
                     o_busy  <= 1'b0;
                     o_done  <= 1'b1;
                     o_pass  <= !w_miss && (o_err_count == 5'd0);
                  end else begin
                     r_state <= S_CHECK;
                  end
               end else if (w_tmo_hit) begin
                  r_state   <= S_DONE;
                  o_busy    <= 1'b0;
                  o_done    <= 1'b1;
                  o_pass    <= 1'b0;
                  o_timeout <= 1'b1;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            S_DONE: begin
               // Any write after the run has completed is a stray write, so it counts as an error.
               if (i_wb.wr_en) begin
                  o_err_count <= w_err_inc;
                  o_pass      <= 1'b0;
                  if (o_err_count == 5'd0)
                     o_first_err_reg <= i_wb.wr_sel;
               end
            end
            default: ;  // S_IDLE: writes are ignored until a run is armed
         endcase
      end
   end

endmodule

// File: tb/tb_fib_writeback_checker.sv
// Scoreboard bench for fib_writeback_checker.
// An independent cycle model predicts every output. Its prediction is queued
// when the stimulus is driven, then popped and compared once the DUT has
// registered that cycle. A second instance checks the modulo wrap of the stream.
module tb_fib_writeback_checker;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fib_writeback_checker_if #(.DATA_W(16)) wb ();
   fib_writeback_checker_if #(.DATA_W(16)) wb2 ();

   logic        busy, done, pass, tmo;
   logic [4:0]  errc;
   logic [3:0]  ferr;
   logic [15:0] expv;

   fib_writeback_checker dut (
      .clk(clk), .reset(reset), .i_wb(wb.slave),
      .o_busy(busy), .o_done(done), .o_pass(pass), .o_timeout(tmo),
      .o_err_count(errc), .o_first_err_reg(ferr), .o_expected(expv)
   );

   logic        busy2, done2, pass2, tmo2;
   logic [4:0]  errc2;
   logic [3:0]  ferr2;
   logic [15:0] expv2;

   fib_writeback_checker #(
      .DATA_W(16), .SEED0(16'h8000), .SEED1(16'h8000), .NUM_WR(4), .TIMEOUT(8)
   ) dut2 (
      .clk(clk), .reset(reset), .i_wb(wb2.slave),
      .o_busy(busy2), .o_done(done2), .o_pass(pass2), .o_timeout(tmo2),
      .o_err_count(errc2), .o_first_err_reg(ferr2), .o_expected(expv2)
   );

   typedef struct {
      logic        busy, done, pass, tmo;
      logic [4:0]  err;
      logic [3:0]  first;
      logic [15:0] expv;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc_n = 0;

   // Reference model state.
   logic [15:0] fib[0:16];
   int          m_st;     // 0 idle, 1 active, 2 done
   int          m_idx, m_timer;
   logic [4:0]  m_err;
   logic [3:0]  m_first;
   logic        m_busy, m_done, m_pass, m_tmo;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc_n, got, exp);
      end
   endtask

   task automatic m_miss(input logic [3:0] sel);
      if (m_err == 5'd0) m_first = sel;
      if (m_err != 5'd31) m_err = m_err + 5'd1;
   endtask

   task automatic m_step(input logic rst, input logic rr, input logic we,
                         input logic [3:0] sel, input logic [15:0] d);
      if (rst || rr) begin
         m_st = rst ? 0 : 1; m_idx = 0; m_timer = 0; m_err = 0; m_first = 0;
         m_busy = !rst; m_done = 0; m_pass = 0; m_tmo = 0;
      end else if (m_st == 1) begin
         if (we) begin
            m_timer = 0;
            if (sel != m_idx[3:0] || d != fib[m_idx]) m_miss(sel);
            m_idx++;
            if (m_idx == 16) begin
               m_st = 2; m_busy = 0; m_done = 1; m_pass = (m_err == 0);
            end
         end else begin
            m_timer++;
            if (m_timer == 64) begin
               m_st = 2; m_busy = 0; m_done = 1; m_pass = 0; m_tmo = 1;
            end
         end
      end else if (m_st == 2 && we) begin
         m_miss(sel);
         m_pass = 0;
      end
   endtask

   // Drive one cycle, queue the model's prediction, then compare after the edge.
   task automatic cyc(input logic rst, input logic rr, input logic we,
                      input logic [3:0] sel, input logic [15:0] d);
      exp_t e;
      reset = rst; wb.reg_reset = rr; wb.wr_en = we; wb.wr_sel = sel; wb.wr_data = d;
      m_step(rst, rr, we, sel, d);
      e.busy = m_busy; e.done = m_done; e.pass = m_pass; e.tmo = m_tmo;
      e.err = m_err; e.first = m_first; e.expv = fib[m_idx];
      q.push_back(e);
      @(posedge clk); #1;
      cyc_n++;
      e = q.pop_front();
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
      chk("pass", 32'(pass), 32'(e.pass));
      chk("timeout", 32'(tmo), 32'(e.tmo));
      chk("err_count", 32'(errc), 32'(e.err));
      chk("first_err_reg", 32'(ferr), 32'(e.first));
      chk("expected", 32'(expv), 32'(e.expv));
      wb.reg_reset = 1'b0; wb.wr_en = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
   endtask

   // Writes reg0..n-1 with short random gaps. Write number bad_k carries bad_v instead of the correct value.
   task automatic run_writes(input int n, input int bad_k, input logic [15:0] bad_v);
      for (int k = 0; k < n; k++) begin
         idle($urandom_range(0, 3));
         cyc(1'b0, 1'b0, 1'b1, 4'(k), (k == bad_k) ? bad_v : fib[k]);
      end
   endtask

   task automatic arm();
      cyc(1'b0, 1'b1, 1'b0, 4'd0, 16'd0);
   endtask

   task automatic w2(input logic [3:0] sel, input logic [15:0] d);
      wb2.wr_en = 1'b1; wb2.wr_sel = sel; wb2.wr_data = d;
      @(posedge clk); #1;
      wb2.wr_en = 1'b0;
   endtask

   initial begin
      fib[0] = 16'd1; fib[1] = 16'd2;
      for (int k = 2; k <= 16; k++) fib[k] = fib[k-2] + fib[k-1];
      wb.reg_reset = 0; wb.wr_en = 0; wb.wr_sel = 0; wb.wr_data = 0;
      wb2.reg_reset = 0; wb2.wr_en = 0; wb2.wr_sel = 0; wb2.wr_data = 0;
      reset = 1;

      // Reset state, then writes in IDLE are ignored.
      cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
      cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 4'(i), fib[i]);

      // A clean run, then a stray write after done.
      arm(); run_writes(16, -1, 16'd0);
      chk("run1 last value", 32'(fib[15]), 32'h063D);
      idle(2);
      cyc(1'b0, 1'b0, 1'b1, 4'd9, 16'd0);
      idle(1);

      // reg5 is written with a bad value.
      arm(); run_writes(16, 5, 16'd14); idle(1);

      // The writes stall after reg3. After 63 idle cycles the run is still alive; the 64th times out.
      arm(); run_writes(4, -1, 16'd0); idle(70);

      // A restart mid-run, then a full clean run.
      arm(); run_writes(8, -1, 16'd0);
      arm(); run_writes(16, -1, 16'd0); idle(1);

      // reg_reset and wr_en in the same cycle: the write is dropped.
      cyc(1'b0, 1'b1, 1'b1, 4'd0, 16'd77);
      run_writes(16, -1, 16'd0);

      // A duplicate wr_sel: one mismatch, and the stream still advances.
      arm();
      for (int k = 0; k < 16; k++) cyc(1'b0, 1'b0, 1'b1, (k == 3) ? 4'd2 : 4'(k), fib[k]);
      idle(1);

      // reset takes priority over reg_reset mid-run.
      arm(); run_writes(3, -1, 16'd0);
      cyc(1'b1, 1'b1, 1'b0, 4'd0, 16'd0);
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 16'd0);

      // Wrap instance: 0x8000 + 0x8000 must be accepted as 0x0000.
      wb2.reg_reset = 1'b1; @(posedge clk); #1; wb2.reg_reset = 1'b0;
      chk("w2 busy armed", 32'(busy2), 32'd1);
      w2(4'd0, 16'h8000);
      w2(4'd1, 16'h8000);
      chk("w2 expected wrap", 32'(expv2), 32'h0000);
      w2(4'd2, 16'h0000);
      chk("w2 err after wrap", 32'(errc2), 32'd0);
      chk("w2 expected after wrap", 32'(expv2), 32'h8000);
      w2(4'd3, 16'h8000);
      chk("w2 done", 32'(done2), 32'd1);
      chk("w2 pass", 32'(pass2), 32'd1);
      chk("w2 timeout", 32'(tmo2), 32'd0);
      chk("w2 first_err_reg", 32'(ferr2), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
